write_buffer_drain: RTL and testbench
=====================================

# write_buffer_drain

Drain side of the cache write buffer: a 4-entry FIFO of evicted 256-bit lines, each tagged with a 27-bit line address, that writes them to memory one at a time over a req/ack handshake. It sits between the cache write-back path (producer, `write_en`/`addr_in`/`data_in`) and the memory port (consumer). It also provides an associative lookup so a cache miss can be served from a pending entry before that entry reaches memory.

## Interface
Parameters:
- DEPTH, 4, number of entries (power of two)
- ADDR_W, 27, line address width
- DATA_W, 256, line data width

Ports:
- clock  in  1  single clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- write_en  in  1  push request from the write-back path
- addr_in  in  ADDR_W  line address to push
- data_in  in  DATA_W  line data to push
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  number of valid entries
- overflow  out  1  sticky; set when a push is attempted while full
- mem_req  out  1  write request to memory
- mem_addr  out  ADDR_W  head entry address, valid while mem_req
- mem_data  out  DATA_W  head entry data, valid while mem_req
- mem_ack  in  1  memory accepted the current request
- lookup_addr  in  ADDR_W  miss address to check against pending entries
- lookup_hit  out  1  a valid entry matches lookup_addr
- lookup_data  out  DATA_W  data of the matching entry, 0 on miss

## Operation
- Storage is a circular array with wr_ptr, rd_ptr, a count register and a per-entry valid bit. Pointers wrap DEPTH-1 -> 0.
- **Push:** on `write_en && !full`, store {data, addr} at wr_ptr, set its valid bit, advance wr_ptr, and increment count. On `write_en && full`, drop the data, set overflow, and leave the pointers unchanged.
- **Drain FSM:**
  - IDLE: if !empty, go to ISSUE.
  - ISSUE: mem_req=1, with mem_addr/mem_data driven from the rd_ptr entry. Hold these until mem_ack. On mem_ack, clear the valid bit, advance rd_ptr, decrement count, and return to IDLE.
- mem_ack is ignored outside ISSUE.
- **Simultaneous push and pop:** count is unchanged, and both pointers advance.
- **Push while full and ack in the same cycle:** the push is rejected, because full is evaluated on the pre-edge count. The pop still completes.
- **Lookup:** combinational compare of lookup_addr against every valid entry.
  - With multiple matches, the newest entry wins (the one closest behind wr_ptr).
  - The entry currently in ISSUE still hits until the edge that pops it.
  - A push in the current cycle is not visible until the next cycle.
- overflow is cleared only by reset.

## Timing
- **Reset values:** wr_ptr=rd_ptr=0, count=0, all valid bits 0, FSM=IDLE, full=0, empty=1, overflow=0, mem_req=0, lookup_hit=0, lookup_data=0. mem_addr and mem_data read as the stale entry at rd_ptr, which is don't-care while mem_req=0.
- **Push to request:** a push accepted at edge k makes empty=0 after edge k. The FSM enters ISSUE at edge k+1, so mem_req is first high in the cycle after k+1. Minimum latency from write_en to mem_req is 2 cycles.
- **Back-to-back entries:** mem_ack at edge n pops the entry and returns to IDLE. The next mem_req rises after edge n+1, giving a one-cycle bubble. Maximum throughput is one line per 2 cycles.
- mem_addr and mem_data must not change while mem_req=1 and mem_ack=0.
- full, empty and count are registered-derived: they reflect all pushes and pops of the previous edge.
- **Reset mid-operation:** reset takes priority over push and ack in the same cycle. mem_req is 0 after the reset edge. An in-flight request is abandoned, and the memory side must tolerate a req that drops without an ack.

## Structure
- Package `wb_pkg` holds:
  - ADDR_W and DATA_W constants;
  - typedef `wb_entry_t` {data, addr, valid} (DATA_W+ADDR_W+1 bits, same layout as the write-back entry);
  - enum `drain_state_t` {IDLE, ISSUE}.
- One sub-module, `wb_match`: parallel address compare plus newest-first priority select. Inputs are the entries, valid bits and wr_ptr; outputs are hit and data.

## Test plan
- **Reset, then push one entry:** reset; write_en with addr=27'h0000123, data=256'hA5…A5 at edge 1 -> empty=0 after edge 1. mem_req=1 with mem_addr=27'h0000123 after edge 2. mem_ack at edge 4 -> empty=1, count=0, mem_req=0.
- **Fill, overflow and wrap:** push 5 entries (addr 1..5) with mem_ack held 0 -> full=1 after the 4th, 5th dropped, overflow=1. Ack all four -> mem_addr sequence 1,2,3,4. Then push addr 6 -> stored at slot 0 (wrap), drained with mem_addr=6.
- **Ack stall:** hold mem_ack=0 for 10 cycles in ISSUE -> mem_req, mem_addr and mem_data stable every cycle. Ack -> exactly one pop.
- **Lookup priority:** push addr 7/data X, addr 7/data Y, addr 9/data Z -> lookup_addr=7 gives hit=1, data=Y. lookup_addr=8 gives hit=0, data=0. After both addr-7 entries drain, lookup_addr=7 gives hit=0.
- **Simultaneous push and pop:** count=2 in ISSUE; write_en and mem_ack in the same cycle -> count stays 2, and the FIFO order is preserved.
- **Reset mid-operation:** count=3 with mem_req=1; assert reset for 1 cycle -> next cycle mem_req=0, empty=1, overflow=0, lookup_hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the cache write buffer.
package wb_pkg;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 256;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              valid;
    } wb_entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } drain_state_t;

endpackage

// File: rtl/wb_match.sv
// Associative lookup over the pending write-buffer entries; newest match wins.
module wb_match #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 256
) (
    input  logic [ADDR_W-1:0]         entry_addr [DEPTH],
    input  logic [DATA_W-1:0]         entry_data [DEPTH],
    input  logic [DEPTH-1:0]          valid,
    input  logic [$clog2(DEPTH)-1:0]  wr_ptr,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from wr_ptr (oldest slot) round to wr_ptr-1 (newest) so later matches override.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = wr_ptr + PW'(i);
            if (valid[idx] && (entry_addr[idx] == lookup_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/write_buffer_drain.sv
// Drain side of the cache write buffer: circular FIFO of evicted lines written
// to memory over req/ack, plus a lookup port for misses on pending lines.
module write_buffer_drain #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
    parameter int unsigned DATA_W = wb_pkg::DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_en,
    input  logic [ADDR_W-1:0]         addr_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    input  logic                      mem_ack,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      lookup_hit,
    output logic [DATA_W-1:0]         lookup_data
);

    import wb_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              push;
    logic              pop;

    drain_state_t state;
    drain_state_t state_next;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = write_en && !full;
    assign pop   = (state == ISSUE) && mem_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            addr_mem[wr_ptr] <= addr_in;
            data_mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr = addr_mem[rd_ptr];
    assign mem_data = data_mem[rd_ptr];

    wb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .entry_addr  (addr_mem),
        .entry_data  (data_mem),
        .valid       (valid),
        .wr_ptr      (wr_ptr),
        .lookup_addr (lookup_addr),
        .hit         (lookup_hit),
        .data        (lookup_data)
    );

endmodule

// File: tb/tb_write_buffer_drain.sv
// Self-checking bench for write_buffer_drain: directed scenarios plus random
// traffic against a queue-based model of the buffer.
module tb_write_buffer_drain;

    localparam int DEPTH = 4;
    localparam int AW    = 27;
    localparam int DW    = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          full, empty, overflow, mem_req, lookup_hit;
    logic [2:0]    count;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] lookup_addr = '0;
    logic [DW-1:0] lookup_data;

    int checks = 0;
    int errors = 0;

    // Model: queue of pending lines (front = oldest), sticky overflow, request flag.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    bit            m_ovf;
    bit            m_req;

    always #5 clock = ~clock;

    write_buffer_drain #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .write_en(write_en), .addr_in(addr_in),
        .data_in(data_in), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_lookup(input logic [AW-1:0] a, output bit h, output logic [DW-1:0] d);
        h = 0;
        d = '0;
        for (int i = q_addr.size() - 1; i >= 0; i--) begin
            if (q_addr[i] == a) begin
                h = 1;
                d = q_data[i];
                break;
            end
        end
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        int sz;
        bit pop;
        @(posedge clock);
        if (reset) begin
            q_addr.delete();
            q_data.delete();
            m_ovf = 0;
            m_req = 0;
        end else begin
            sz  = q_addr.size();
            pop = m_req && mem_ack;
            if (write_en && sz == DEPTH) m_ovf = 1;
            if (write_en && sz < DEPTH) begin
                q_addr.push_back(addr_in);
                q_data.push_back(data_in);
            end
            if (pop) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            // A request is held until acked; a new one starts once the buffer was seen non-empty.
            m_req = m_req ? !mem_ack : (sz != 0);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; write_en = 0; mem_ack = 0;
        step();
        reset = 0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en = 1; addr_in = a; data_in = d;
        step();
        write_en = 0;
    endtask

    task automatic test_reset();
        lookup_addr = '0;
        reset = 1;
        step(); step();
        reset = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL reset_lookup got hit %b data %h exp 0", lookup_hit, lookup_data); end
    endtask

    task automatic test_single();
        logic [DW-1:0] a5 = {32{8'hA5}};
        do_reset();
        push(27'h0000123, a5);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_e1 got %b exp 0", empty); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_e1 got %b exp 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req_e2 got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 27'h0000123) begin errors++; $display("FAIL single_addr got %h exp 0000123", mem_addr); end
        checks++; if (mem_data !== a5) begin errors++; $display("FAIL single_data got %h exp %h", mem_data, a5); end
        step();
        mem_ack = 1;
        step();
        mem_ack = 0;
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL single_drained got empty %b count %0d exp 1 0", empty, count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_after_ack got %b exp 0", mem_req); end
    endtask

    task automatic test_fill_overflow_wrap();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            push(AW'(i), rand_data());
            if (i == 4) begin
                checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_full got full %b count %0d exp 1 4", full, count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_overflow got ovf %b count %0d exp 1 4", overflow, count); end
        for (int n = 1; n <= 4; n++) begin
            for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== AW'(n)) begin errors++; $display("FAIL fill_drain_%0d got req %b addr %h exp 1 %h", n, mem_req, mem_addr, n); end
            // First ack coincides with a push into the full buffer: push must be rejected.
            if (n == 1) begin write_en = 1; addr_in = 27'h99; data_in = rand_data(); end
            mem_ack = 1;
            step();
            mem_ack = 0; write_en = 0;
            if (n == 1) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_ack_count got %0d exp 3", count); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b exp 1", empty); end
        push(27'h6, rand_data());
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 27'h6) begin errors++; $display("FAIL wrap_addr got req %b addr %h exp 1 6", mem_req, mem_addr); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
        mem_ack = 1; step(); mem_ack = 0;
    endtask

    task automatic test_ack_stall();
        logic [AW-1:0] a0 = 27'h1ABCDE0, a1 = 27'h0F0F0F1;
        logic [DW-1:0] d0 = rand_data(), d1 = rand_data();
        do_reset();
        push(a0, d0);
        push(a1, d1);
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        for (int c = 0; c < 10; c++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== a0 || mem_data !== d0) begin errors++; $display("FAIL stall_hold_%0d got req %b addr %h exp 1 %h", c, mem_req, mem_addr, a0); end
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL stall_count_%0d got %0d exp 2", c, count); end
            step();
        end
        mem_ack = 1; step(); mem_ack = 0;
        checks++; if (count !== 3'd1 || mem_req !== 1'b0) begin errors++; $display("FAIL stall_one_pop got count %0d req %b exp 1 0", count, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== a1 || mem_data !== d1) begin errors++; $display("FAIL stall_next got req %b addr %h exp 1 %h", mem_req, mem_addr, a1); end
    endtask

    task automatic test_lookup_priority();
        logic [DW-1:0] dx = rand_data(), dy = rand_data(), dz = rand_data(), dn = rand_data();
        do_reset();
        push(27'h7, dx); push(27'h7, dy); push(27'h9, dz);
        lookup_addr = 27'h7; #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== dy) begin errors++; $display("FAIL lookup_newest got hit %b data %h exp 1 %h", lookup_hit, lookup_data, dy); end
        lookup_addr = 27'h8; #1;
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL lookup_miss got hit %b data %h exp 0 0", lookup_hit, lookup_data); end
        lookup_addr = 27'h9; #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== dz) begin errors++; $display("FAIL lookup_9 got hit %b data %h exp 1 %h", lookup_hit, lookup_data, dz); end
        write_en = 1; addr_in = 27'h55; data_in = dn; lookup_addr = 27'h55; #1;
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_same_cycle_push got %b exp 0", lookup_hit); end
        step(); write_en = 0;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== dn) begin errors++; $display("FAIL lookup_after_push got hit %b data %h exp 1 %h", lookup_hit, lookup_data, dn); end
        lookup_addr = 27'h7;
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        mem_ack = 1; step(); mem_ack = 0;
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        checks++; if (mem_req !== 1'b1 || lookup_hit !== 1'b1 || lookup_data !== dy) begin errors++; $display("FAIL lookup_in_issue got req %b hit %b data %h exp 1 1 %h", mem_req, lookup_hit, lookup_data, dy); end
        mem_ack = 1; step(); mem_ack = 0;
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL lookup_drained got hit %b data %h exp 0 0", lookup_hit, lookup_data); end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] exp_a [2] = '{27'hB, 27'hC};
        do_reset();
        push(27'hA, rand_data()); push(27'hB, rand_data());
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        checks++; if (count !== 3'd2 || mem_addr !== 27'hA) begin errors++; $display("FAIL simul_pre got count %0d addr %h exp 2 a", count, mem_addr); end
        write_en = 1; addr_in = 27'hC; data_in = rand_data(); mem_ack = 1;
        step();
        write_en = 0; mem_ack = 0;
        checks++; if (count !== 3'd2 || mem_req !== 1'b0) begin errors++; $display("FAIL simul_count got count %0d req %b exp 2 0", count, mem_req); end
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp_a[n]) begin errors++; $display("FAIL simul_order_%0d got req %b addr %h exp 1 %h", n, mem_req, mem_addr, exp_a[n]); end
            mem_ack = 1; step(); mem_ack = 0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push(AW'(32'h10 + i), rand_data());
        mem_ack = 1; step(); mem_ack = 0;
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) step();
        checks++; if (count !== 3'd3 || mem_req !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got count %0d req %b ovf %b exp 3 1 1", count, mem_req, overflow); end
        lookup_addr = 27'h12;
        reset = 1; write_en = 1; addr_in = 27'h12; mem_ack = 1;
        step();
        reset = 0; write_en = 0; mem_ack = 0;
        checks++; if (mem_req !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL mid_state got req %b empty %b count %0d exp 0 1 0", mem_req, empty, count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", overflow); end
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL mid_lookup got hit %b data %h exp 0 0", lookup_hit, lookup_data); end
    endtask

    task automatic test_random();
        bit            eh;
        logic [DW-1:0] ed;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (count !== 3'(q_addr.size()) || full !== (q_addr.size() == DEPTH) || empty !== (q_addr.size() == 0)) begin
                errors++; $display("FAIL rnd_occupancy cyc %0d got count %0d full %b empty %b exp count %0d", cyc, count, full, empty, q_addr.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d got %b exp %b", cyc, overflow, m_ovf); end
            checks++; if (mem_req !== m_req) begin errors++; $display("FAIL rnd_mem_req cyc %0d got %b exp %b", cyc, mem_req, m_req); end
            if (m_req) begin
                checks++; if (mem_addr !== q_addr[0] || mem_data !== q_data[0]) begin errors++; $display("FAIL rnd_head cyc %0d got addr %h exp %h", cyc, mem_addr, q_addr[0]); end
            end
            reset       = ($urandom_range(0, 79) == 0);
            write_en    = $urandom_range(0, 1);
            addr_in     = AW'($urandom_range(0, 7));
            data_in     = rand_data();
            mem_ack     = ($urandom_range(0, 2) != 0);
            lookup_addr = AW'($urandom_range(0, 7));
            #1;
            model_lookup(lookup_addr, eh, ed);
            checks++; if (lookup_hit !== eh || lookup_data !== ed) begin errors++; $display("FAIL rnd_lookup cyc %0d addr %h got hit %b data %h exp %b %h", cyc, lookup_addr, lookup_hit, lookup_data, eh, ed); end
            step();
        end
        reset = 0; write_en = 0; mem_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fill_overflow_wrap();
        test_ack_stall();
        test_lookup_priority();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
